inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_if.sv | 22 ++
 rtl/inst_loader.sv | 121 ++++++++++++
 tb/tb_inst_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Instruction word stream into the loader.
// Source drives valid/data/last, the loader answers with ready.
interface inst_loader_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        in_ready;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output in_ready
   );
endinterface

// File: rtl/inst_loader.sv
// Packs streamed words into pairs and writes them to instruction memory
// while holding the core halted.
module inst_loader #(
   parameter logic [8:0] BASE_ADDR = 9'd0,
   parameter logic [8:0] MAX_ADDR  = 9'd511
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   inst_loader_if.slave        link,
   output logic                enable_load_ex_mem,
   output logic [8:0]          InstExMemAddress,
   output logic [31:0]         InstExMemData1,
   output logic [31:0]         InstExMemData2,
   output logic                cpu_halt,
   output logic                load_done,
   output logic                overflow,
   output logic [9:0]          pairs_written
);

   typedef enum logic [2:0] {
      IDLE,
      LO,
      HI,
      WRITE,
      DONE,
      ERR
   } state_t;

   state_t state;
   state_t state_nx;
   logic   last_seen;
   logic   at_max;

   assign at_max = (InstExMemAddress >= MAX_ADDR);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx           = state;
      link.in_ready      = 1'b0;
      enable_load_ex_mem = 1'b0;
      cpu_halt           = 1'b1;
      load_done          = 1'b0;
      overflow           = 1'b0;
      unique case (state)
         IDLE: begin
            cpu_halt = 1'b0;
            if (start) state_nx = LO;
         end
         LO: begin
            link.in_ready = 1'b1;
            if (link.in_valid)
               state_nx = link.in_last ? WRITE : HI;
         end
         HI: begin
            link.in_ready = 1'b1;
            if (link.in_valid) state_nx = WRITE;
         end
         WRITE: begin
            enable_load_ex_mem = 1'b1;
            if (last_seen)   state_nx = DONE;
            else if (at_max) state_nx = ERR;
            else             state_nx = LO;
         end
         DONE: begin
            load_done = 1'b1;
            state_nx  = IDLE;
         end
         ERR: begin
            overflow = 1'b1;
            if (start) state_nx = LO;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Address and data stay frozen through WRITE; they move only on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         InstExMemAddress <= BASE_ADDR;
         InstExMemData1   <= 32'h0;
         InstExMemData2   <= 32'h0;
         pairs_written    <= 10'd0;
         last_seen        <= 1'b0;
      end else begin
         unique case (state)
            IDLE, ERR: begin
               if (start) begin
                  InstExMemAddress <= BASE_ADDR;
                  pairs_written    <= 10'd0;
                  last_seen        <= 1'b0;
               end
            end
            LO: begin
               if (link.in_valid) begin
                  InstExMemData1 <= link.in_data;
                  last_seen      <= link.in_last;
                  if (link.in_last) InstExMemData2 <= 32'h0;
               end
            end
            HI: begin
               if (link.in_valid) begin
                  InstExMemData2 <= link.in_data;
                  last_seen      <= link.in_last;
               end
            end
            WRITE: begin
               pairs_written <= pairs_written + 10'd1;
               if (!last_seen && !at_max)
                  InstExMemAddress <= InstExMemAddress + 9'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized and directed checks of inst_loader against a word-list model.
module tb_inst_loader;
   localparam logic [8:0] BASE = 9'd500;
   localparam logic [8:0] MAX  = 9'd511;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        en;
   logic [8:0]  addr;
   logic [31:0] d1;
   logic [31:0] d2;
   logic        halt;
   logic        done;
   logic        ovf;
   logic [9:0]  pairs;

   always #5 clk = ~clk;

   inst_loader_if link ();

   inst_loader #(
      .BASE_ADDR(BASE),
      .MAX_ADDR (MAX)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .link              (link.slave),
      .enable_load_ex_mem(en),
      .InstExMemAddress  (addr),
      .InstExMemData1    (d1),
      .InstExMemData2    (d2),
      .cpu_halt          (halt),
      .load_done         (done),
      .overflow          (ovf),
      .pairs_written     (pairs)
   );

   // model: session flags plus the list of words accepted this session
   bit          m_act, m_wr, m_done, m_err, m_last;
   int          m_pairs;
   logic [31:0] m_words[$];

   logic [31:0] src_d[$];
   bit          src_l[$];

   logic [8:0]  lg_a[$];
   logic [31:0] lg_d1[$];
   logic [31:0] lg_d2[$];
   int          n_done;
   int          n_acc = 0;
   int          passed = 0;
   int          total = 0;
   int          cyc_n = 0;
   int          vprob = 100;
   bit          toggle_mode = 1'b0;
   int          acc0;

   always @(posedge clk)
      if (!rst && link.in_valid && link.in_ready) n_acc <= n_acc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic check_cycle();
      int p;
      logic [31:0] e2;
      chk("in_ready", 32'(link.in_ready),
          32'(m_act && !m_wr && !m_done));
      chk("strobe", 32'(en), 32'(m_wr));
      chk("cpu_halt", 32'(halt), 32'(m_act || m_err));
      chk("load_done", 32'(done), 32'(m_done));
      chk("overflow", 32'(ovf), 32'(m_err));
      chk("pairs", 32'(pairs), 32'(m_pairs));
      if (en === 1'b1) begin
         lg_a.push_back(addr);
         lg_d1.push_back(d1);
         lg_d2.push_back(d2);
      end
      if (done === 1'b1) n_done++;
      if (m_wr) begin
         p  = 2 * m_pairs;
         e2 = (p + 1 < m_words.size()) ? m_words[p+1] : 32'h0;
         chk("wr_addr", 32'(addr), 32'(int'(BASE) + m_pairs));
         chk("wr_data1", d1, m_words[p]);
         chk("wr_data2", d2, e2);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit v,
                             input bit l, input logic [31:0] d);
      if (r) begin
         m_act = 0; m_wr = 0; m_done = 0; m_err = 0; m_last = 0;
         m_pairs = 0;
         m_words.delete();
      end else if (m_wr) begin
         m_wr = 0;
         if (m_last) m_done = 1;
         else if (int'(BASE) + m_pairs >= int'(MAX)) begin
            m_err = 1;
            m_act = 0;
         end
         m_pairs++;
      end else if (m_done) begin
         m_done = 0;
         m_act  = 0;
      end else if (!m_act) begin
         if (s) begin
            m_act = 1; m_err = 0; m_last = 0; m_pairs = 0;
            m_words.delete();
         end
      end else if (v) begin
         m_words.push_back(d);
         m_last = l;
         void'(src_d.pop_front());
         void'(src_l.pop_front());
         if (l || (m_words.size() % 2 == 0)) m_wr = 1;
      end
   endtask

   task automatic cycle(input bit s, input bit r);
      bit v;
      @(negedge clk);
      check_cycle();
      cyc_n++;
      start = s;
      rst   = r;
      if (toggle_mode) v = cyc_n[0];
      else v = ($urandom_range(99) < vprob);
      if (src_d.size() > 0 && v) begin
         link.in_valid = 1'b1;
         link.in_data  = src_d[0];
         link.in_last  = src_l[0];
      end else begin
         link.in_valid = 1'b0;
         link.in_data  = $urandom;
         link.in_last  = 1'($urandom_range(1));
      end
      model_step(r, s, link.in_valid, link.in_last, link.in_data);
   endtask

   task automatic run(input int n);
      repeat (n) cycle(0, 0);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((m_act || m_wr || m_done) && k < budget) begin
         cycle(0, 0);
         k++;
      end
      if (m_act || m_wr || m_done) chk("timeout", 32'(m_act), 0);
   endtask

   task automatic clr_log();
      lg_a.delete();
      lg_d1.delete();
      lg_d2.delete();
      n_done = 0;
      acc0 = n_acc;
   endtask

   task automatic push(input logic [31:0] w, input bit l);
      src_d.push_back(w);
      src_l.push_back(l);
   endtask

   initial begin
      int n;
      bit wl;
      rst = 1'b1;
      start = 1'b0;
      link.in_valid = 1'b0;
      link.in_data  = 32'h0;
      link.in_last  = 1'b0;
      model_step(1, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("rst ready", 32'(link.in_ready), 0);
      chk("rst strobe", 32'(en), 0);
      chk("rst halt", 32'(halt), 0);
      chk("rst done", 32'(done), 0);
      chk("rst ovf", 32'(ovf), 0);
      chk("rst pairs", 32'(pairs), 0);
      chk("rst addr", 32'(addr), 32'd500);
      chk("rst data1", d1, 32'h0);
      chk("rst data2", d2, 32'h0);
      rst = 1'b0;

      // four words, even pairing
      clr_log();
      push(32'hA000_0000, 0); push(32'hA000_0001, 0);
      push(32'hA000_0002, 0); push(32'hA000_0003, 1);
      cycle(1, 0);
      wait_idle(40);
      cycle(0, 0);
      chk("even nwr", lg_a.size(), 2);
      chk("even a0", 32'(lg_a[0]), 32'd500);
      chk("even a1", 32'(lg_a[1]), 32'd501);
      chk("even d1_0", lg_d1[0], 32'hA000_0000);
      chk("even d2_0", lg_d2[0], 32'hA000_0001);
      chk("even d1_1", lg_d1[1], 32'hA000_0002);
      chk("even d2_1", lg_d2[1], 32'hA000_0003);
      chk("even pairs", 32'(pairs), 2);
      chk("even done", n_done, 1);
      chk("even halt", 32'(halt), 0);

      // odd count pads a NOP
      clr_log();
      push(32'hB000_0000, 0); push(32'hB000_0001, 0);
      push(32'hB000_0002, 1);
      cycle(1, 0);
      wait_idle(40);
      chk("odd a1", 32'(lg_a[1]), 32'd501);
      chk("odd d1_1", lg_d1[1], 32'hB000_0002);
      chk("odd d2_1", lg_d2[1], 32'h0);
      chk("odd pairs", 32'(pairs), 2);

      // valid toggling every cycle
      clr_log();
      toggle_mode = 1'b1;
      for (int i = 0; i < 8; i++) push(32'hC000_0000 + 32'(i), i == 7);
      cycle(1, 0);
      wait_idle(80);
      toggle_mode = 1'b0;
      chk("tog nwr", lg_a.size(), 4);
      chk("tog d1_2", lg_d1[2], 32'hC000_0004);
      chk("tog d2_3", lg_d2[3], 32'hC000_0007);
      chk("tog acc", n_acc - acc0, 8);

      // overflow: 12 pairs fit, words 25 and 26 must wait
      clr_log();
      for (int i = 0; i < 26; i++) push(32'hD000_0000 + 32'(i), 0);
      cycle(1, 0);
      run(80);
      chk("ovf flag", 32'(ovf), 1);
      chk("ovf nwr", lg_a.size(), 12);
      chk("ovf last addr", 32'(lg_a[11]), 32'd511);
      chk("ovf acc", n_acc - acc0, 24);
      src_d.delete();
      src_l.delete();
      cycle(1, 0);
      cycle(0, 0);
      chk("ovf cleared", 32'(ovf), 0);
      chk("ovf restart halt", 32'(halt), 1);
      cycle(0, 1);
      cycle(0, 0);

      // reset in the middle of a pair
      clr_log();
      push(32'hE000_0000, 0); push(32'hE000_0001, 1);
      cycle(1, 0);
      cycle(0, 0);
      cycle(0, 1);
      cycle(0, 0);
      chk("mid rst strobe", 32'(en), 0);
      chk("mid rst halt", 32'(halt), 0);
      chk("mid rst nwr", lg_a.size(), 0);
      chk("mid rst acc", n_acc - acc0, 1);
      src_d.delete();
      src_l.delete();

      // start while collecting the high word is ignored
      clr_log();
      push(32'hF000_0000, 0); push(32'hF000_0001, 0);
      push(32'hF000_0002, 0); push(32'hF000_0003, 1);
      cycle(1, 0);
      cycle(0, 0);
      cycle(1, 0);
      wait_idle(40);
      chk("hi start a0", 32'(lg_a[0]), 32'd500);
      chk("hi start a1", 32'(lg_a[1]), 32'd501);
      chk("hi start d1_1", lg_d1[1], 32'hF000_0002);
      chk("hi start pairs", 32'(pairs), 2);

      // random sessions
      for (int t = 0; t < 60; t++) begin
         src_d.delete();
         src_l.delete();
         n  = $urandom_range(1, 30);
         wl = ($urandom_range(9) != 0);
         vprob = $urandom_range(30, 100);
         for (int i = 0; i < n; i++) push($urandom, wl && (i == n - 1));
         run($urandom_range(0, 2));
         cycle(1, 0);
         for (int k = 0; k < 4 * n + 20; k++) begin
            if (!(m_act || m_wr || m_done)) break;
            cycle($urandom_range(19) == 0, $urandom_range(199) == 0);
         end
         if (m_act || m_wr || m_done) cycle(0, 1);
      end
      vprob = 100;
      run(3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
